// File: rtl/guess_entry_pkg.sv
// Shared types and constants for the guess-entry keypad block.
//   entry_state_t : entry FSM states (ENTRY, FULL, SEND, LOCK)
//   NUM_DIGITS    : digits in one guess
//   MAX_DIGIT     : largest legal BCD key code
//   EMPTY_NIBBLE  : marker for an unused buffer position
//   set_nibble    : replace one nibble of the 16-bit buffer (index 0 = [15:12])
package bc_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        FULL  = 2'd1,
        SEND  = 2'd2,
        LOCK  = 2'd3
    } entry_state_t;

    localparam int          NUM_DIGITS   = 4;
    localparam logic [3:0]  MAX_DIGIT    = 4'd9;
    localparam logic [3:0]  EMPTY_NIBBLE = 4'hF;
    localparam logic [15:0] EMPTY_BUF    = {4{EMPTY_NIBBLE}};

    function automatic logic [15:0] set_nibble(input logic [15:0] value,
                                               input logic [2:0]  idx,
                                               input logic [3:0]  nib);
        logic [15:0] result;
        result = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                result[15 - 4*i -: 4] = nib;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/guess_entry_if.sv
// Keypad strobes in, guess/display status out.
//   master : keypad side (drives key strobes, observes results)
//   slave  : guess_entry side
//   digit_in/digit_valid, backspace, enter, clear : one-cycle key strobes
//   guess/confirm : submitted guess and its one-cycle qualifier
//   count/preview : live entry buffer for display
//   err           : stretched reject indication
interface guess_entry_if;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        backspace;
    logic        enter;
    logic        clear;
    logic [15:0] guess;
    logic        confirm;
    logic [2:0]  count;
    logic [15:0] preview;
    logic        err;

    modport master (
        output digit_in, digit_valid, backspace, enter, clear,
        input  guess, confirm, count, preview, err
    );

    modport slave (
        input  digit_in, digit_valid, backspace, enter, clear,
        output guess, confirm, count, preview, err
    );
endinterface

// File: rtl/guess_entry_digit_check.sv
// Combinational key validation: rejects a digit that is not BCD or that
// already appears among the buffered digits.
//   preview  : current entry buffer (index 0 = [15:12])
//   count    : number of valid digits in preview
//   digit_in : candidate key code
//   reject   : 1 when the candidate must not be accepted
module bc_digit_check
    import bc_pkg::*;
(
    input  logic [15:0] preview,
    input  logic [2:0]  count,
    input  logic [3:0]  digit_in,
    output logic        reject
);

    always_comb begin
        reject = (digit_in > MAX_DIGIT);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            // Only positions already filled take part in the duplicate test.
            if ((3'(i) < count) && (preview[15 - 4*i -: 4] == digit_in)) begin
                reject = 1'b1;
            end
        end
    end

endmodule

// File: rtl/guess_entry.sv
// Four-digit guess entry controller for a keypad.
// Collects unique BCD digits, supports backspace/clear, submits a full
// guess on enter, then locks out the keypad briefly after each submit.
//   clock : single clock, posedge
//   reset : synchronous, active-low
//   bus   : guess_entry_if.slave (key strobes in, guess/preview/status out)
module guess_entry
    import bc_pkg::*;
#(
    parameter int ERR_CYCLES  = 4,
    parameter int LOCK_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    guess_entry_if.slave  bus
);

    localparam int ERR_W  = (ERR_CYCLES  > 1) ? $clog2(ERR_CYCLES)  : 1;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    entry_state_t      state;
    logic [15:0]       entry_buf;
    logic [2:0]        entry_count;
    logic [15:0]       guess_value;
    logic              confirm_pulse;
    logic              err_flag;
    logic [ERR_W-1:0]  err_cnt;
    logic [LOCK_W-1:0] lock_cnt;

    logic digit_reject;
    logic do_clear;
    logic do_back;
    logic do_enter;
    logic do_digit;
    logic rejected;

    bc_digit_check u_digit_check (
        .preview  (entry_buf),
        .count    (entry_count),
        .digit_in (bus.digit_in),
        .reject   (digit_reject)
    );

    // Only one strobe is acted on per cycle; SEND and LOCK ignore them all.
    always_comb begin
        do_clear = 1'b0;
        do_back  = 1'b0;
        do_enter = 1'b0;
        do_digit = 1'b0;
        if ((state == ENTRY) || (state == FULL)) begin
            if (bus.clear) begin
                do_clear = 1'b1;
            end else if (bus.backspace) begin
                do_back = 1'b1;
            end else if (bus.enter) begin
                do_enter = 1'b1;
            end else if (bus.digit_valid) begin
                do_digit = 1'b1;
            end
        end
        rejected = (do_enter && (state == ENTRY)) ||
                   (do_digit && ((state == FULL) || digit_reject));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ENTRY;
            entry_buf     <= EMPTY_BUF;
            entry_count   <= 3'd0;
            guess_value   <= 16'h0000;
            confirm_pulse <= 1'b0;
            err_flag      <= 1'b0;
            err_cnt       <= '0;
            lock_cnt      <= '0;
        end else begin
            confirm_pulse <= 1'b0;

            // A fresh rejection restarts the stretch even if err is already high.
            if (rejected) begin
                err_flag <= 1'b1;
                err_cnt  <= ERR_LAST;
            end else if (err_flag) begin
                if (err_cnt == '0) begin
                    err_flag <= 1'b0;
                end else begin
                    err_cnt <= err_cnt - 1'b1;
                end
            end

            case (state)
                ENTRY, FULL: begin
                    if (do_clear) begin
                        entry_buf   <= EMPTY_BUF;
                        entry_count <= 3'd0;
                        state       <= ENTRY;
                    end else if (do_back) begin
                        if (entry_count != 3'd0) begin
                            entry_buf   <= set_nibble(entry_buf, entry_count - 3'd1, EMPTY_NIBBLE);
                            entry_count <= entry_count - 3'd1;
                            state       <= ENTRY;
                        end
                    end else if (do_enter) begin
                        if (state == FULL) begin
                            guess_value   <= entry_buf;
                            confirm_pulse <= 1'b1;
                            state         <= SEND;
                        end
                    end else if (do_digit && !rejected) begin
                        entry_buf   <= set_nibble(entry_buf, entry_count, bus.digit_in);
                        entry_count <= entry_count + 3'd1;
                        if (entry_count == 3'(NUM_DIGITS - 1)) begin
                            state <= FULL;
                        end
                    end
                end
                SEND: begin
                    entry_buf   <= EMPTY_BUF;
                    entry_count <= 3'd0;
                    lock_cnt    <= '0;
                    state       <= LOCK;
                end
                LOCK: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state <= ENTRY;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

    assign bus.guess   = guess_value;
    assign bus.confirm = confirm_pulse;
    assign bus.count   = entry_count;
    assign bus.preview = entry_buf;
    assign bus.err     = err_flag;

endmodule
